// File: rtl/gp_regfile_pkg.sv
// gp_regfile_pkg
// Shared definitions for the multi-port general-purpose register file:
//   - state_t       : controller states (idle / sequential clear sweep)
//   - DESC_MAX_W    : widest descriptor the field helpers accept
//   - fieldGet      : generic "width bits starting at lsb" extraction
//   - getIndex      : register index field of a read/write descriptor
//   - getBank       : bank field, sitting directly above the index field
package gp_regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int unsigned DESC_MAX_W = 64;

    // Descriptors are zero-extended to DESC_MAX_W by the caller so one
    // helper serves every DATA_W the register file is built with.
    function automatic int unsigned fieldGet(
        input logic [DESC_MAX_W-1:0] desc,
        input int unsigned           lsb,
        input int unsigned           width
    );
        logic [DESC_MAX_W-1:0] shifted;
        shifted = desc >> lsb;
        shifted = shifted & ((64'd1 << width) - 64'd1);
        return shifted[31:0];
    endfunction

    function automatic int unsigned getIndex(
        input logic [DESC_MAX_W-1:0] desc,
        input int unsigned           idxLsb,
        input int unsigned           idxW
    );
        return fieldGet(desc, idxLsb, idxW);
    endfunction

    function automatic int unsigned getBank(
        input logic [DESC_MAX_W-1:0] desc,
        input int unsigned           idxLsb,
        input int unsigned           idxW,
        input int unsigned           bankW
    );
        return fieldGet(desc, idxLsb + idxW, bankW);
    endfunction

endpackage

// File: rtl/gp_regfile_rdport.sv
// gp_regfile_rdport
// One registered read port of the register file.
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset (clears the output register)
//   src_i       : read descriptor (index + bank fields)
//   re_i        : read enable; when low the output register holds
//   regsFlat_i  : all registers, register i at bits [i*DATA_W +: DATA_W]
//   wrAccept_i  : a write is being committed at this edge
//   wrIdx_i     : index of that write
//   wrData_i    : data of that write
//   clrActive_i : the clear sweep is zeroing a register at this edge
//   clrIdx_i    : index the sweep is zeroing
//   q_o         : read data, valid one cycle after the enabled read
module gp_regfile_rdport
    import gp_regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_COUNT = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned IDX_LSB   = 3,
    parameter int unsigned BANK_W    = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATA_W-1:0]           src_i,
    input  logic                        re_i,
    input  logic [REG_COUNT*DATA_W-1:0] regsFlat_i,
    input  logic                        wrAccept_i,
    input  logic [IDX_W-1:0]            wrIdx_i,
    input  logic [DATA_W-1:0]           wrData_i,
    input  logic                        clrActive_i,
    input  logic [IDX_W-1:0]            clrIdx_i,
    output logic [DATA_W-1:0]           q_o
);

    logic [IDX_W-1:0]  rdIdx;
    logic              bankLocal;
    logic [DATA_W-1:0] regVal;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    // Decode the descriptor; only bank 0 addresses this file.
    always_comb begin
        rdIdx     = IDX_W'(getIndex(DESC_MAX_W'(src_i), IDX_LSB, IDX_W));
        bankLocal = (getBank(DESC_MAX_W'(src_i), IDX_LSB, IDX_W, BANK_W) == 0);
        regVal    = regsFlat_i[rdIdx*DATA_W +: DATA_W];
    end

    // Same-edge updates to the addressed register are forwarded so the port
    // returns the value the register holds after this edge. The sweep and an
    // accepted write never coincide, so their relative order is irrelevant.
    always_comb begin
        q_d = q_q;
        if (re_i) begin
            if (!bankLocal) begin
                q_d = '0;
            end else if (clrActive_i && (clrIdx_i == rdIdx)) begin
                q_d = '0;
            end else if (wrAccept_i && (wrIdx_i == rdIdx)) begin
                q_d = wrData_i;
            end else begin
                q_d = regVal;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gp_regfile_mp.sv
// gp_regfile_mp
// General-purpose register file with one write port, two registered read
// ports and a sequential clear sweep.
//   CLK          : clock, all state on the rising edge
//   RST_N        : synchronous active-low reset
//   DST, D_IN    : write descriptor and write data
//   WE           : write request
//   CLR          : start a one-register-per-cycle clear of the whole file
//   SRC_A, SRC_B : read descriptors; RE_A, RE_B read enables
//   Q_A, Q_B     : registered read data (latency 1)
//   WR_ERR       : one-cycle pulse after a rejected write request
//   BUSY         : clear sweep in progress
//   DEBUG        : combinational view of register DBG_IDX
module gp_regfile_mp
    import gp_regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_COUNT = 8,
    parameter int unsigned IDX_LSB   = 3,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned DBG_IDX   = 6
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DST,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              WE,
    input  logic              CLR,
    input  logic [DATA_W-1:0] SRC_A,
    input  logic [DATA_W-1:0] SRC_B,
    input  logic              RE_A,
    input  logic              RE_B,
    output logic [DATA_W-1:0] Q_A,
    output logic [DATA_W-1:0] Q_B,
    output logic              WR_ERR,
    output logic              BUSY,
    output logic [DATA_W-1:0] DEBUG
);

    localparam int unsigned      IDX_W    = $clog2(REG_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);
    localparam logic [IDX_W-1:0] DBG_SEL  = IDX_W'(DBG_IDX);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            sweepIdx_q, sweepIdx_d;
    logic                        wrErr_q;
    logic [DATA_W-1:0]           regs_q [REG_COUNT];
    logic [REG_COUNT*DATA_W-1:0] regsFlat;

    logic [IDX_W-1:0]            wrIdx;
    logic                        wrBankLocal;
    logic                        wrAccept;
    logic                        clrActive;

    // Write qualification: CLR and an active sweep both take priority over
    // the write port, and foreign-bank writes are refused outright.
    always_comb begin
        wrIdx       = IDX_W'(getIndex(DESC_MAX_W'(DST), IDX_LSB, IDX_W));
        wrBankLocal = (getBank(DESC_MAX_W'(DST), IDX_LSB, IDX_W, BANK_W) == 0);
        clrActive   = (state_q == ST_CLEAR);
        wrAccept    = WE && wrBankLocal && !clrActive && !CLR;
    end

    // Sweep controller: CLR is only honoured in idle, and the sweep returns
    // to idle on the cycle that zeroes the last register.
    always_comb begin
        state_d    = state_q;
        sweepIdx_d = sweepIdx_q;
        case (state_q)
            ST_IDLE: begin
                if (CLR) begin
                    state_d    = ST_CLEAR;
                    sweepIdx_d = '0;
                end
            end
            ST_CLEAR: begin
                if (sweepIdx_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    sweepIdx_d = '0;
                end else begin
                    sweepIdx_d = sweepIdx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                sweepIdx_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            sweepIdx_q <= '0;
            wrErr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweepIdx_q <= sweepIdx_d;
            wrErr_q    <= WE && !wrAccept;
        end
    end

    // Storage: the sweep owns the array while clearing, otherwise the write
    // port updates at most one register per edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clrActive) begin
            regs_q[sweepIdx_q] <= '0;
        end else if (wrAccept) begin
            regs_q[wrIdx] <= D_IN;
        end
    end

    always_comb begin
        regsFlat = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            regsFlat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    gp_regfile_rdport #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT),
        .IDX_W     (IDX_W),
        .IDX_LSB   (IDX_LSB),
        .BANK_W    (BANK_W)
    ) u_rdport_a (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .src_i       (SRC_A),
        .re_i        (RE_A),
        .regsFlat_i  (regsFlat),
        .wrAccept_i  (wrAccept),
        .wrIdx_i     (wrIdx),
        .wrData_i    (D_IN),
        .clrActive_i (clrActive),
        .clrIdx_i    (sweepIdx_q),
        .q_o         (Q_A)
    );

    gp_regfile_rdport #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT),
        .IDX_W     (IDX_W),
        .IDX_LSB   (IDX_LSB),
        .BANK_W    (BANK_W)
    ) u_rdport_b (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .src_i       (SRC_B),
        .re_i        (RE_B),
        .regsFlat_i  (regsFlat),
        .wrAccept_i  (wrAccept),
        .wrIdx_i     (wrIdx),
        .wrData_i    (D_IN),
        .clrActive_i (clrActive),
        .clrIdx_i    (sweepIdx_q),
        .q_o         (Q_B)
    );

    assign WR_ERR = wrErr_q;
    assign BUSY   = clrActive;
    assign DEBUG  = regs_q[DBG_SEL];

endmodule

// File: doc/gp_regfile_mp.md
GP_REGFILE_MP -- requirements
Module: gp_regfile_mp

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter REG_COUNT, default 8, register count; power of two, 2..32; IDX_W = log2(REG_COUNT).
REQ-003 Parameter IDX_LSB, default 3, LSB of index field in SRC_A/SRC_B/DST descriptors.
REQ-004 Parameter BANK_W, default 2, width of bank field directly above index field; bank 0 = this file.
REQ-005 Parameter DBG_IDX, default 6, register driven on DEBUG.
REQ-006 CLK  in  1  single clock; all state on rising edge.
REQ-007 RST_N  in  1  synchronous, active-low reset.
REQ-008 DST  in  DATA_W  write descriptor (index + bank fields).
REQ-009 D_IN  in  DATA_W  write data.
REQ-010 WE  in  1  write request.
REQ-011 CLR  in  1  start sequential clear of all registers.
REQ-012 SRC_A, SRC_B  in  DATA_W  read descriptors, ports A/B.
REQ-013 RE_A, RE_B  in  1  read enables.
REQ-014 Q_A, Q_B  out  DATA_W  registered read data.
REQ-015 WR_ERR  out  1  registered pulse: write rejected.
REQ-016 BUSY  out  1  clear sweep in progress.
REQ-017 DEBUG  out  DATA_W  combinational copy of register DBG_IDX.

Function
REQ-018 Index = descriptor[IDX_LSB +: IDX_W]; bank = descriptor[IDX_LSB+IDX_W +: BANK_W]; other bits ignored.
REQ-019 FSM states IDLE, CLEAR; IDLE->CLEAR on CLR in IDLE; CLEAR->IDLE after sweep index REG_COUNT-1 cleared; CLR in CLEAR ignored.
REQ-020 CLEAR writes 0 to one register per cycle, index 0 first, ascending; sweep lasts exactly REG_COUNT cycles.
REQ-021 BUSY = 1 exactly while state is CLEAR (first cycle after CLR sampled through cycle clearing REG_COUNT-1).
REQ-022 Write accepted when WE=1, DST bank=0, state IDLE, CLR=0: reg[index] <= D_IN at that edge.
REQ-023 WE=1 with bank!=0, or BUSY=1, or CLR=1 (CLR wins) -> no write; WR_ERR=1 for following cycle only.
REQ-024 Read: RE_x=1 samples register at edge; Q_x valid next cycle (latency 1); RE_x=0 holds Q_x.
REQ-025 Read bypass: accepted write to same index in same cycle -> Q_x gets D_IN; sweep clearing same index -> Q_x gets 0.
REQ-026 Read with SRC_x bank!=0 -> Q_x = 0.
REQ-027 Both ports may read same or different registers in same cycle, independently.
REQ-028 DEBUG reflects reg[DBG_IDX] with no cycle delay after register update.

Reset
REQ-029 RST_N=0 at edge: all registers, Q_A, Q_B, WR_ERR = 0; state IDLE; BUSY = 0; sweep index 0.
REQ-030 Reset mid-sweep aborts CLEAR; reset overrides WE, CLR, RE in same cycle.

Structure
REQ-031 Package gp_regfile_pkg holds FSM state enum and index/bank field extraction functions.
REQ-032 Sub-module gp_regfile_rdport (index decode, bank check, bypass, output register), instantiated once per read port.
REQ-033 Storage as flat register array; no latches, no async paths other than DEBUG.

Verification
REQ-034 Reset, WE DST=0x0018 D_IN=0xBEEF; next cycle RE_A SRC_A=0x0018 -> Q_A=0xBEEF one cycle later.
REQ-035 Same cycle WE DST=0x0010 D_IN=0x1234 and RE_B SRC_B=0x0010 -> Q_B=0x1234 next cycle (bypass).
REQ-036 WE DST=0x0058 (bank 1) -> register 3 unchanged, WR_ERR high one cycle; RE_A SRC_A=0x0058 -> Q_A=0.
REQ-037 Fill all 8 registers non-zero, pulse CLR -> BUSY high 8 cycles; WE during sweep -> WR_ERR, no write; afterwards all reads 0.
REQ-038 CLR, RST_N low in 3rd sweep cycle -> BUSY=0, state IDLE, all registers 0 next cycle.
REQ-039 Write 0xA5A5 to index 6 -> DEBUG=0xA5A5 same cycle as update; repeat REQ-034 with DATA_W=32, REG_COUNT=16.
